// File: rtl/cpu_bus_cycle_initiator_if.sv
// rtl/cpu_bus_cycle_initiator_if.sv - request/response and 8088-style local bus signal bundle
interface cpu_bus_cycle_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [19:0] req_address;
    logic [7:0]  req_wdata;
    logic        req_lock;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_error;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data_bus;
    logic        cpu_data_oe;
    logic [2:0]  processor_status;
    logic        processor_lock_n;
    logic        processor_ready;
    logic [7:0]  data_bus_in;

    modport master (
        input  req_valid, req_type, req_address, req_wdata, req_lock,
        input  processor_ready, data_bus_in,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output cpu_address, cpu_data_bus, cpu_data_oe, processor_status, processor_lock_n
    );

    modport slave (
        output req_valid, req_type, req_address, req_wdata, req_lock,
        output processor_ready, data_bus_in,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  cpu_address, cpu_data_bus, cpu_data_oe, processor_status, processor_lock_n
    );
endinterface

// File: rtl/cpu_bus_cycle_initiator.sv
// rtl/cpu_bus_cycle_initiator.sv - turns core requests into T1/T2/T3/Tw/T4 local bus cycles
module cpu_bus_cycle_initiator #(
    parameter int WAIT_TIMEOUT = 1023,
    parameter int INTA_PAIR    = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    cpu_bus_cycle_initiator_if.master bus
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 2);

    localparam logic [2:0] TY_INTA    = 3'b000;
    localparam logic [2:0] TY_IO_WR   = 3'b010;
    localparam logic [2:0] TY_HALT    = 3'b011;
    localparam logic [2:0] TY_MEM_WR  = 3'b110;
    localparam logic [2:0] TY_ILLEGAL = 3'b111;
    localparam logic [2:0] PASSIVE    = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

    state_t          state_q, state_d;
    logic [2:0]      type_q, type_d;
    logic [19:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            lock_q, lock_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            ill_q, ill_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            phase_q, phase_d;

    logic is_write, is_read, inta_first, pair_next, req_ready_w, in_cycle;

    assign is_write   = (type_q == TY_IO_WR) || (type_q == TY_MEM_WR);
    assign is_read    = type_q inside {3'b000, 3'b001, 3'b100, 3'b101};
    assign inta_first = (INTA_PAIR != 0) && (type_q == TY_INTA) && !phase_q;
    // First INTA of a pair chains straight into the second; it is neither a response nor an accept slot.
    assign pair_next  = (state_q == S_T4) && inta_first && !err_q;
    assign req_ready_w = reset_n && ((state_q == S_IDLE) || ((state_q == S_T4) && !pair_next));
    assign in_cycle   = state_q inside {S_T1, S_T2, S_T3, S_TW, S_T4};

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lock_d  = lock_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ill_d   = 1'b0;
        cnt_d   = cnt_q;
        phase_d = phase_q;

        case (state_q)
            S_T1: state_d = S_T2;
            S_T2: state_d = (type_q == TY_HALT) ? S_T4 : S_T3;
            S_T3, S_TW: begin
                if (bus.processor_ready) begin
                    if (is_read && !inta_first) rdata_d = bus.data_bus_in;
                    state_d = S_T4;
                end else if ((WAIT_TIMEOUT != 0) && (state_q == S_TW) &&
                             (cnt_q == CW'(WAIT_TIMEOUT))) begin
                    err_d   = 1'b1;
                    state_d = S_T4;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_TW;
                end
            end
            S_T4: begin
                cnt_d = '0;
                if (pair_next) begin
                    phase_d = 1'b1;
                    state_d = S_T1;
                end else begin
                    phase_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        if (bus.req_valid && req_ready_w) begin
            err_d   = 1'b0;
            cnt_d   = '0;
            phase_d = 1'b0;
            if (bus.req_type == TY_ILLEGAL) begin
                ill_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                type_d  = bus.req_type;
                addr_d  = bus.req_address;
                wdata_d = bus.req_wdata;
                lock_d  = bus.req_lock;
                state_d = S_T1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            type_q  <= PASSIVE;
            addr_q  <= '0;
            wdata_q <= '0;
            lock_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lock_q  <= lock_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.req_ready        = req_ready_w;
    assign bus.cpu_address      = addr_q;
    assign bus.cpu_data_bus     = wdata_q;
    assign bus.cpu_data_oe      = is_write && (state_q inside {S_T2, S_T3, S_TW, S_T4});
    assign bus.processor_status = (in_cycle && (state_q != S_T4)) ? type_q : PASSIVE;
    assign bus.processor_lock_n = !(in_cycle && (inta_first || lock_q));
    assign bus.resp_valid       = ill_q || ((state_q == S_T4) && !pair_next);
    assign bus.resp_error       = ill_q || ((state_q == S_T4) && err_q);
    assign bus.resp_rdata       = rdata_q;
endmodule
